// File: rtl/ov7670_capture_pkg.sv
// Shared types and constants for the OV7670 write-side capture path.
package ov7670_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_e;

    localparam int BYTE_W = 8;
    localparam int PIX_W  = 16;

    // RGB565 field positions inside a captured word
    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam int DEF_H_PIXELS    = 640;
    localparam int DEF_V_LINES     = 480;
    localparam int DEF_SKIP_FRAMES = 2;
    localparam int DEF_CW          = 12;

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera pixel bus plus async-FIFO write port; master is the capture block.
interface ov7670_capture_if;
    import ov7670_capture_pkg::*;

    logic              cam_vsync;
    logic              cam_href;
    logic [BYTE_W-1:0] cam_data;
    logic              full_fifo;
    logic              wr_en;
    logic [PIX_W-1:0]  dout;

    modport master (
        input  cam_vsync, cam_href, cam_data, full_fifo,
        output wr_en, dout
    );

    modport slave (
        output cam_vsync, cam_href, cam_data, full_fifo,
        input  wr_en, dout
    );

endinterface

// File: rtl/ov7670_capture_sync_edge.sv
// One-stage input register for the camera bus with VSYNC edge detection.
module cam_sync_edge
    import ov7670_capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_hr_q,
    output logic [BYTE_W-1:0] o_d_q,
    output logic              o_vs_rise,
    output logic              o_vs_fall
);
    logic              r_vs_q;
    logic              r_vs_qq;
    logic              r_hr_q;
    logic [BYTE_W-1:0] r_d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
            r_hr_q  <= 1'b0;
            r_d_q   <= '0;
        end else begin
            r_vs_q  <= i_vsync;
            r_vs_qq <= r_vs_q;
            r_hr_q  <= i_href;
            r_d_q   <= i_data;
        end
    end

    assign o_hr_q    = r_hr_q;
    assign o_d_q     = r_d_q;
    assign o_vs_rise = r_vs_q & ~r_vs_qq;
    assign o_vs_fall = ~r_vs_q & r_vs_qq;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: frame gating, byte pairing into RGB565 and FIFO write with
// overflow and geometry error flags.
module ov7670_capture
    import ov7670_capture_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int CW          = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_done,
    ov7670_capture_if.master  io_bus,
    output logic              o_frame_start,
    output logic              o_overflow,
    output logic              o_geom_err,
    output logic [CW-1:0]     o_pixel_x,
    output logic [CW-1:0]     o_pixel_y
);
    localparam logic [CW-1:0] LP_H    = CW'(H_PIXELS);
    localparam logic [CW-1:0] LP_V    = CW'(V_LINES);
    localparam logic [CW-1:0] LP_ONE  = CW'(1);
    localparam logic [7:0]    LP_SKIP = 8'(SKIP_FRAMES);

    logic              w_hr_q;
    logic [BYTE_W-1:0] w_d_q;
    logic              w_vs_rise;
    logic              w_vs_fall;

    cam_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_vsync   (io_bus.cam_vsync),
        .i_href    (io_bus.cam_href),
        .i_data    (io_bus.cam_data),
        .o_hr_q    (w_hr_q),
        .o_d_q     (w_d_q),
        .o_vs_rise (w_vs_rise),
        .o_vs_fall (w_vs_fall)
    );

    cap_state_e        r_state, w_state_n;
    logic [CW-1:0]     r_x, w_x_n;
    logic [CW-1:0]     r_y, w_y_n, w_y_end;
    logic              r_bsel, w_bsel_n;
    logic [BYTE_W-1:0] r_hi, w_hi_n;
    logic [7:0]        r_skip, w_skip_n;
    logic              r_fs, w_fs_n;
    logic [PIX_W-1:0]  r_word, w_word_n;
    logic              w_wvld_n;
    logic              r_ovf, w_ovf_n;
    logic              r_gerr, w_gerr_n;
    logic              r_hr_d;
    logic [1:0]        r_vld_pipe;
    logic [PIX_W-1:0]  r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_x_n     = r_x;
        w_y_n     = r_y;
        w_y_end   = r_y;
        w_bsel_n  = r_bsel;
        w_hi_n    = r_hi;
        w_skip_n  = r_skip;
        w_fs_n    = 1'b0;
        w_word_n  = r_word;
        w_wvld_n  = 1'b0;
        w_ovf_n   = r_ovf;
        w_gerr_n  = r_gerr;

        case (r_state)
            ST_IDLE: begin
                w_skip_n = '0;
                if (i_cfg_done) w_state_n = ST_SKIP;
            end
            ST_SKIP: begin
                if (r_skip >= LP_SKIP)  w_state_n = ST_WAIT_VS;
                else if (w_vs_rise)     w_skip_n  = r_skip + 8'd1;
            end
            ST_WAIT_VS: begin
                if (w_vs_fall) begin
                    w_fs_n    = 1'b1;
                    w_x_n     = '0;
                    w_y_n     = '0;
                    w_bsel_n  = 1'b0;
                    w_state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_hr_q) begin
                    w_bsel_n = ~r_bsel;
                    if (!r_bsel) begin
                        w_hi_n = w_d_q;
                    end else begin
                        w_word_n = {r_hi, w_d_q};
                        // Over-long lines and a full FIFO both drop the word; never stall.
                        if (r_x >= LP_H)              w_gerr_n = 1'b1;
                        else if (io_bus.full_fifo)    w_ovf_n  = 1'b1;
                        else                          w_wvld_n = 1'b1;
                        if (r_x != {CW{1'b1}})        w_x_n    = r_x + LP_ONE;
                    end
                end else if (r_hr_d) begin
                    w_bsel_n = 1'b0;
                    if (r_x != '0) begin
                        w_y_end = r_y + LP_ONE;
                        if (r_x != LP_H) w_gerr_n = 1'b1;
                        w_x_n = '0;
                    end
                end
                w_y_n = w_y_end;
                // Frame-end check sees the line that may close on this same cycle.
                if (w_vs_rise) begin
                    if (w_y_end != LP_V) w_gerr_n = 1'b1;
                    w_state_n = ST_WAIT_VS;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        if (!i_cfg_done) begin
            w_state_n = ST_IDLE;
            w_x_n     = '0;
            w_y_n     = '0;
            w_bsel_n  = 1'b0;
            w_skip_n  = '0;
            w_fs_n    = 1'b0;
            w_wvld_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_bsel     <= 1'b0;
            r_hi       <= '0;
            r_skip     <= '0;
            r_fs       <= 1'b0;
            r_word     <= '0;
            r_ovf      <= 1'b0;
            r_gerr     <= 1'b0;
            r_hr_d     <= 1'b0;
            r_vld_pipe <= '0;
            r_dout     <= '0;
        end else begin
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_bsel     <= w_bsel_n;
            r_hi       <= w_hi_n;
            r_skip     <= w_skip_n;
            r_fs       <= w_fs_n;
            r_word     <= w_word_n;
            r_ovf      <= w_ovf_n;
            r_gerr     <= w_gerr_n;
            r_hr_d     <= w_hr_q;
            r_vld_pipe <= {r_vld_pipe[0] & i_cfg_done, w_wvld_n};
            if (r_vld_pipe[0]) r_dout <= r_word;
        end
    end

    assign io_bus.wr_en  = r_vld_pipe[1];
    assign io_bus.dout   = r_dout;
    assign o_frame_start = r_fs;
    assign o_overflow    = r_ovf;
    assign o_geom_err    = r_gerr;
    assign o_pixel_x     = r_x;
    assign o_pixel_y     = r_y;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a frame-level expectation model.
module tb_ov7670_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int SK = 2;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_done = 1'b0;
    logic          fs, ovf, gerr;
    logic [CW-1:0] px, py;

    ov7670_capture_if bus();

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .SKIP_FRAMES(SK), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cfg_done    (cfg_done),
        .io_bus        (bus),
        .o_frame_start (fs),
        .o_overflow    (ovf),
        .o_geom_err    (gerr),
        .o_pixel_x     (px),
        .o_pixel_y     (py)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] w;
    } exp_t;

    exp_t        wq[$];
    int          fsq[$];
    logic [15:0] wlog[$];
    logic [7:0]  tbl [4];

    int cyc = 0, n_cmp = 0, n_bad = 0, n_wr = 0, n_fs = 0;
    bit m_cfg = 0, m_cap = 0, m_ovf = 0, m_gerr = 0;
    int m_rises = 0, m_y = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every cycle: write strobe, data and frame_start against the expectation queues.
    always @(negedge clk) begin
        bit ew, ef;
        if (!rst) begin
            ew = (wq.size() > 0 && wq[0].t == cyc);
            chk("wr_en", {31'd0, bus.wr_en}, {31'd0, ew});
            if (ew) begin
                chk("dout", {16'd0, bus.dout}, {16'd0, wq[0].w});
                void'(wq.pop_front());
            end
            if (bus.wr_en === 1'b1) begin
                n_wr++;
                wlog.push_back(bus.dout);
            end
            ef = (fsq.size() > 0 && fsq[0] == cyc);
            chk("frame_start", {31'd0, fs}, {31'd0, ef});
            if (ef) void'(fsq.pop_front());
            if (fs === 1'b1) n_fs++;
        end
    end

    function automatic logic [7:0] pbyte(input int fr, input int ln, input int b);
        if (fr == 2 && ln == 0 && b < 4) return tbl[b];
        return 8'((fr * 53 + ln * 17 + b * 3 + 1) & 255);
    endfunction

    task automatic rise_model();
        if (m_cfg) begin
            if (m_cap && m_y != V) m_gerr = 1;
            m_cap = 0;
            m_rises++;
        end
    endtask

    task automatic send_lines(input int fr, input int from, input int to,
                              input int odd_ln, input int drop_ln, input bit tight);
        for (int ln = from; ln < to; ln++) begin
            int nb, n;
            bit pend, cap_line;
            logic [7:0] hi, d;
            exp_t e;
            nb = (ln == odd_ln) ? 2 * H - 1 : 2 * H;
            pend = 0;
            hi = 8'h00;
            for (int b = 0; b < nb; b++) begin
                @(negedge clk);
                d = pbyte(fr, ln, b);
                bus.cam_href  = 1'b1;
                bus.cam_data  = d;
                bus.full_fifo = pend;
                pend = 0;
                if (b % 2 == 0) hi = d;
                else if (m_cap) begin
                    if (b / 2 >= H) m_gerr = 1;
                    else if (ln == drop_ln && b / 2 >= 3 && b / 2 <= 5) begin
                        m_ovf = 1;
                        pend = 1;
                    end else begin
                        e.t = cyc + 3;
                        e.w = {hi, d};
                        wq.push_back(e);
                    end
                end
            end
            @(negedge clk);
            bus.cam_href  = 1'b0;
            bus.full_fifo = pend;
            n = nb / 2;
            cap_line = m_cap;
            if (m_cap && n != 0) begin
                m_y++;
                if (n != H) m_gerr = 1;
            end
            if (tight && ln == to - 1) begin
                bus.cam_vsync = 1'b1;
                rise_model();
            end
            @(negedge clk);
            bus.full_fifo = 1'b0;
            if (cap_line && n != 0) chk("pixel_x_eol", {20'd0, px}, n);
            repeat (4) @(negedge clk);
            if (cap_line) begin
                chk("pixel_x_gap", {20'd0, px}, 0);
                chk("pixel_y", {20'd0, py}, m_y);
            end
            chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
            chk("geom_err", {31'd0, gerr}, {31'd0, m_gerr});
        end
    endtask

    task automatic vs_pulse(input bit already_high);
        if (!already_high) begin
            @(negedge clk);
            bus.cam_vsync = 1'b1;
            rise_model();
        end
        repeat (4) @(negedge clk);
        bus.cam_vsync = 1'b0;
        if (m_cfg && m_rises >= SK) begin
            fsq.push_back(cyc + 2);
            m_cap = 1;
            m_y = 0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int fr, input int odd_ln, input int drop_ln, input bit tight);
        send_lines(fr, 0, V, odd_ln, drop_ln, tight);
        vs_pulse(tight);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, {31'd0, bus.wr_en}, 0);
        chk({tag, "_dout"},  {16'd0, bus.dout}, 0);
        chk({tag, "_fs"},    {31'd0, fs}, 0);
        chk({tag, "_ovf"},   {31'd0, ovf}, 0);
        chk({tag, "_gerr"},  {31'd0, gerr}, 0);
        chk({tag, "_px"},    {20'd0, px}, 0);
        chk({tag, "_py"},    {20'd0, py}, 0);
    endtask

    initial begin
        int base, base_fs;
        tbl[0] = 8'hF8; tbl[1] = 8'h00; tbl[2] = 8'h07; tbl[3] = 8'hE0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        bus.full_fifo = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cfg_done = 1'b1;
        m_cfg = 1;
        repeat (4) @(negedge clk);

        // Two settling frames, then the first captured frame
        send_frame(0, -1, -1, 0);
        send_frame(1, -1, -1, 0);
        chk("skip_frames_no_writes", n_wr, 0);
        chk("frame_start_once", n_fs, 1);
        base = n_wr;
        send_frame(2, -1, -1, 0);
        chk("frame3_words", n_wr - base, H * V);
        chk("first_word", {16'd0, wlog[0]}, 32'h0000F800);
        chk("second_word", {16'd0, wlog[1]}, 32'h000007E0);
        chk("frame3_gerr", {31'd0, gerr}, 0);

        // Three pixels dropped on a full FIFO; last href fall coincides with vsync rise
        base = n_wr;
        send_frame(3, -1, 1, 1);
        chk("ovf_frame_words", n_wr - base, H * V - 3);
        chk("ovf_sticky", {31'd0, ovf}, 1);
        chk("ovf_no_gerr", {31'd0, gerr}, 0);

        // Short line with odd trailing byte
        base = n_wr;
        send_frame(4, 2, -1, 0);
        chk("short_frame_words", n_wr - base, H * V - 1);
        chk("short_gerr", {31'd0, gerr}, 1);

        // Reset in the middle of a captured frame
        send_lines(5, 0, 2, -1, -1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midrst");
        wq.delete();
        fsq.delete();
        m_ovf = 0; m_gerr = 0; m_cap = 0; m_rises = 0; m_y = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = n_wr;
        base_fs = n_fs;
        send_lines(5, 2, V, -1, -1, 0);
        vs_pulse(0);
        send_frame(6, -1, -1, 0);
        chk("post_rst_no_writes", n_wr - base, 0);
        chk("post_rst_fs", n_fs - base_fs, 1);
        base = n_wr;
        send_frame(7, -1, 0, 0);
        chk("post_rst_words", n_wr - base, H * V - 3);
        chk("post_rst_ovf", {31'd0, ovf}, 1);

        // Configuration drops mid-capture
        base = n_wr;
        send_lines(8, 0, 2, -1, -1, 0);
        @(negedge clk);
        cfg_done = 1'b0;
        m_cfg = 0; m_cap = 0; m_rises = 0;
        repeat (2) @(negedge clk);
        chk("cfgdrop_ovf_kept", {31'd0, ovf}, 1);
        chk("cfgdrop_px", {20'd0, px}, 0);
        chk("cfgdrop_py", {20'd0, py}, 0);
        send_lines(8, 2, V, -1, -1, 0);
        vs_pulse(0);
        chk("cfgdrop_words", n_wr - base, 2 * H);
        chk("cfgdrop_queue_empty", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Write-side counterpart of the VGA read path.
- Samples the OV7670 parallel pixel bus in the camera PCLK domain.
- Pairs bytes into RGB565 words and pushes them into the async FIFO that the VGA side drains.
- Gates capture on SCCB configuration done and frame-skip, and flags FIFO overflow and frame geometry errors.

Parameters:
- H_PIXELS, 640, RGB565 pixels per valid line (2 bytes each).
- V_LINES, 480, valid lines per frame.
- SKIP_FRAMES, 2, complete frames discarded after cfg_done rises (camera settling).
- CW, 12, width of pixel_x/pixel_y counters.

Ports:
- clk  in  1  camera PCLK; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_done  in  1  level; SCCB register programming complete.
- cam_vsync  in  1  OV7670 VSYNC, high during vertical blanking.
- cam_href  in  1  OV7670 HREF, high while line bytes are valid.
- cam_data  in  8  OV7670 D[7:0].
- full_fifo  in  1  async FIFO write-side full.
- wr_en  out  1  one-cycle FIFO write strobe.
- dout  out  16  RGB565 word {R[15:11],G[10:5],B[4:0]}.
- frame_start  out  1  one-cycle pulse at start of each captured frame.
- overflow  out  1  sticky; pixel dropped because FIFO full.
- geom_err  out  1  sticky; line or frame size mismatch.
- pixel_x, pixel_y  out  CW  current pixel column and line of the captured frame.

Behaviour:
- Reset: all outputs 0, state IDLE, byte_sel 0, skip counter 0.
- Input register: cam_vsync, cam_href and cam_data are registered once (vs_q, hr_q, d_q).
- Edge detect: a second vs_qq stage gives vs_rise and vs_fall.
- All outputs are registered.

State machine:
- IDLE: wait for cfg_done=1, then go to SKIP.
- SKIP: count vs_rise. After SKIP_FRAMES rises, go to WAIT_VS.
- WAIT_VS: on vs_fall, pulse frame_start for 1 cycle, clear pixel_x/pixel_y, go to CAPTURE.
- CAPTURE: on vs_rise, go to WAIT_VS. If pixel_y != V_LINES at that point, set geom_err.
- Any state: cfg_done=0 forces IDLE next cycle. Counters clear, sticky flags hold.

Byte pairing (CAPTURE, hr_q=1):
- byte_sel=0: store d_q as the high byte.
- byte_sel=1: form the word {hi, d_q}.
- byte_sel toggles every cycle hr_q=1.

Write timing and overflow:
- Second byte on cam_data at edge k gives wr_en=1 and dout valid after edge k+2.
- If full_fifo=1 when the word forms: wr_en stays 0, overflow set, pixel_x still increments (drop, never stall).
- Words with pixel_x >= H_PIXELS are not written and set geom_err.

Line end (hr_q falling):
- byte_sel clears; an odd trailing byte is discarded.
- If pixel_x != 0: pixel_y increments; pixel_x != H_PIXELS sets geom_err; pixel_x clears.
- href with no bytes (pixel_x=0) does not increment pixel_y.

Other timing:
- Simultaneous vs_rise and href falling edge: line end is processed first, then the frame ends.
- Outside CAPTURE: wr_en=0 and bytes are ignored.
- rst mid-frame clears everything. Capture resumes only after cfg_done plus SKIP_FRAMES, then a vs_fall.

Clearing sticky flags: overflow and geom_err clear only on rst.

Decomposition:
- Package ov7670_capture_pkg: state encoding (IDLE, SKIP, WAIT_VS, CAPTURE), RGB565 field bit positions, default geometry constants.
- Sub-module cam_sync_edge: one-stage input register plus vsync rise/fall detect. Everything else stays in ov7670_capture.

Test Plan:
- Bring-up skip: rst, cfg_done=1, SKIP_FRAMES=2, drive 3 frames of 640x480 -> no wr_en in frames 1-2; frame 3 gives frame_start once and exactly 307200 wr_en pulses.
- Byte pairing: line bytes 0xF8,0x00,0x07,0xE0 -> dout 0xF800 then 0x07E0, each wr_en two cycles after its second byte.
- Overflow: full_fifo=1 for 3 pixel times mid-line -> 3 words missing, overflow=1, pixel_x still reaches 640, geom_err=0.
- Geometry: one line of 639 pixels plus an odd trailing byte -> geom_err=1, odd byte not written, next line starts at pixel_x=0.
- Reset mid-frame: assert rst at line 200 -> all outputs 0 immediately; after release, no writes until cfg_done plus 2 skipped frames plus vs_fall.
- Config drop: cfg_done=0 in CAPTURE -> IDLE next cycle, wr_en=0, sticky flags retained.
